encrypt_seq: RTL

ENCRYPT_SEQ -- requirements
Module: encrypt_seq

---
 rtl/encrypt_pkg.sv | 28 ++
 rtl/lfsr7.sv | 34 +++
 rtl/encrypt_seq.sv | 138 +++++++++++++
 3 files changed

// File: rtl/encrypt_pkg.sv
// Shared FSM state type, memory map and constants for the LFSR stream encryptor.
package encrypt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_PRE,
        RD_PTRN,
        RD_INIT,
        CAP_INIT,
        RD_MSG,
        WR_CT,
        DONE
    } state_e;

    localparam logic [7:0]  PRE_ADDR  = 8'd61;
    localparam logic [7:0]  PTRN_ADDR = 8'd62;
    localparam logic [7:0]  INIT_ADDR = 8'd63;
    localparam logic [7:0]  OUT_BASE  = 8'd64;
    localparam int unsigned NUM_OUT   = 64;
    localparam logic [3:0]  MIN_PRE   = 4'd10;
    localparam logic [7:0]  ASCII_OFS = 8'h20;

    // Preamble lengths shorter than the minimum are clamped up to it.
    function automatic logic [3:0] eff_pre(input logic [3:0] raw);
        return (raw < MIN_PRE) ? MIN_PRE : raw;
    endfunction

endpackage

// File: rtl/lfsr7.sv
// 7-bit Fibonacci-style LFSR with programmable taps; a zero seed loads as 7'h01.
module lfsr7 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [6:0] seed_i,
    input  logic       step_i,
    input  logic [6:0] taps_i,
    output logic [6:0] state_o
);

    logic [6:0] state_q;
    logic [6:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == 7'd0) ? 7'h01 : seed_i;
        end else if (step_i) begin
            state_d = {state_q[5:0], ^(state_q & taps_i)};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= 7'h01;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/encrypt_seq.sv
// Reads preamble/taps/seed and plaintext from memory, writes 64 parity-tagged
// LFSR-encrypted bytes to 64..127, then holds Ack until Start returns high.
module encrypt_seq
    import encrypt_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    output logic       Ack,
    output logic [7:0] mem_addr,
    output logic       mem_rd_en,
    input  logic [7:0] mem_rdata,
    output logic       mem_wr_en,
    output logic [7:0] mem_wdata
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_OUT - 1);

    state_e     state_q, state_d;
    logic       start_q;
    logic [5:0] idx_q, idx_d;
    logic [3:0] pre_q, pre_d;
    logic [6:0] taps_q, taps_d;

    logic       lfsr_load;
    logic       lfsr_step;
    logic [6:0] lfsr;
    logic       in_pre;
    logic       next_in_pre;
    logic [6:0] ct7;
    logic       unused_rdata_msb;

    assign unused_rdata_msb = mem_rdata[7];

    assign in_pre      = idx_q < {2'b00, pre_q};
    assign next_in_pre = (idx_q + 6'd1) < {2'b00, pre_q};
    // Only the low 7 bits of (rdata - 0x20) reach the ciphertext.
    assign ct7 = in_pre ? lfsr : ((mem_rdata[6:0] - ASCII_OFS[6:0]) ^ lfsr);

    lfsr7 u_lfsr (
        .clk_i   (Clk),
        .rst_ni  (Reset),
        .load_i  (lfsr_load),
        .seed_i  (mem_rdata[6:0]),
        .step_i  (lfsr_step),
        .taps_i  (taps_q),
        .state_o (lfsr)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pre_d     = pre_q;
        taps_d    = taps_q;
        lfsr_load = 1'b0;
        lfsr_step = 1'b0;
        Ack       = 1'b0;
        mem_rd_en = 1'b0;
        mem_wr_en = 1'b0;
        mem_addr  = 8'd0;
        mem_wdata = 8'd0;

        unique case (state_q)
            IDLE: begin
                if (start_q && !Start) begin
                    state_d = RD_PRE;
                    idx_d   = 6'd0;
                end
            end
            RD_PRE: begin
                mem_rd_en = 1'b1;
                mem_addr  = PRE_ADDR;
                state_d   = RD_PTRN;
            end
            RD_PTRN: begin
                mem_rd_en = 1'b1;
                mem_addr  = PTRN_ADDR;
                pre_d     = eff_pre(mem_rdata[3:0]);
                state_d   = RD_INIT;
            end
            RD_INIT: begin
                mem_rd_en = 1'b1;
                mem_addr  = INIT_ADDR;
                taps_d    = mem_rdata[6:0];
                state_d   = CAP_INIT;
            end
            CAP_INIT: begin
                lfsr_load = 1'b1;
                state_d   = in_pre ? WR_CT : RD_MSG;
            end
            RD_MSG: begin
                mem_rd_en = 1'b1;
                mem_addr  = {2'b00, idx_q} - {4'b0000, pre_q};
                state_d   = WR_CT;
            end
            WR_CT: begin
                mem_wr_en = 1'b1;
                mem_addr  = OUT_BASE + {2'b00, idx_q};
                mem_wdata = {^ct7, ct7};
                lfsr_step = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 6'd1;
                    state_d = next_in_pre ? WR_CT : RD_MSG;
                end
            end
            DONE: begin
                Ack = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Start high outside IDLE aborts a run, or releases DONE.
        if (state_q != IDLE && Start) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            start_q <= 1'b0;
            idx_q   <= 6'd0;
            pre_q   <= MIN_PRE;
            taps_q  <= 7'd0;
        end else begin
            state_q <= state_d;
            start_q <= Start;
            idx_q   <= idx_d;
            pre_q   <= pre_d;
            taps_q  <= taps_d;
        end
    end

endmodule
